// File: rtl/spi_req_arbiter.sv
// Round-robin sequencer sharing one SPI master among N_REQ requesters.
// Issues a frame, waits for acceptance and done, then acks; a watchdog aborts hung frames.
module spi_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic                busy,
    output logic                spi_start,
    output logic [DW-1:0]       spi_din,
    input  logic                spi_cs,
    input  logic                spi_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      ptr, ptr_n, idx, idx_n, pick;
    logic               found;
    logic [CW-1:0]      cnt, cnt_n;
    logic               done_q, done_rise, expired;
    logic               start_n, err_n;
    logic [DW-1:0]      din_n;
    logic [N_REQ-1:0]   ack_n;

    assign done_rise = spi_done & ~done_q;
    assign expired   = (cnt >= CW'(TIMEOUT - 1));

    // First requester at or after ptr, wrapping around
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        idx_n   = idx;
        cnt_n   = cnt;
        start_n = spi_start;
        din_n   = spi_din;
        ack_n   = '0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && spi_cs) begin
                    idx_n   = pick;
                    din_n   = req_data[int'(pick)*DW +: DW];
                    start_n = 1'b1;
                    cnt_n   = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n = cnt + 1'b1;
                if (!spi_cs) begin
                    start_n = 1'b0;
                    state_n = WAIT_DONE;
                end else if (expired) begin
                    start_n    = 1'b0;
                    ack_n[idx] = 1'b1;
                    err_n      = 1'b1;
                    state_n    = ACK;
                end
            end
            WAIT_DONE: begin
                cnt_n = cnt + 1'b1;
                if (done_rise) begin
                    ack_n[idx] = 1'b1;
                    state_n    = ACK;
                end else if (expired) begin
                    ack_n[idx] = 1'b1;
                    err_n      = 1'b1;
                    state_n    = ACK;
                end
            end
            ACK: begin
                ptr_n   = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            done_q    <= 1'b0;
            spi_start <= 1'b0;
            spi_din   <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            done_q    <= spi_done;
            spi_start <= start_n;
            spi_din   <= din_n;
            ack       <= ack_n;
            err       <= err_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: two instances, one with a short watchdog.
module tb_spi_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [47:0] req_data = {12'h8D3, 12'h47E, 12'h1B9, 12'hA5C};
    logic        cs = 1'b1, done = 1'b0;
    logic [3:0]  ack;
    logic        err, busy, start;
    logic [11:0] din;
    logic        t_cs = 1'b1, t_done = 1'b0;
    logic [3:0]  t_ack;
    logic        t_err, t_busy, t_start;
    logic [11:0] t_din;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    spi_req_arbiter #(.N_REQ(4), .DW(12), .TIMEOUT(4096)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .err(err), .busy(busy), .spi_start(start),
        .spi_din(din), .spi_cs(cs), .spi_done(done)
    );

    spi_req_arbiter #(.N_REQ(4), .DW(12), .TIMEOUT(64)) dut_t (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(t_ack), .err(t_err), .busy(t_busy), .spi_start(t_start),
        .spi_din(t_din), .spi_cs(t_cs), .spi_done(t_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // One frame on the main instance: cs low csd cycles after start,
    // done rises dd cycles later and stays high dl cycles
    task automatic serve(input string tag, input logic [3:0] exp_ack,
                         input logic [11:0] exp_din, input int csd,
                         input int dd, input int dl, input logic [3:0] clr);
        int w = 0;
        int extra = 0;
        while (!start && w < 20) begin
            tick(1);
            w++;
        end
        chk({tag, "_start"}, start, 1);
        chk({tag, "_din"}, din, exp_din);
        tick(csd);
        chk({tag, "_hold"}, start, 1);
        cs = 1'b0;
        tick(1);
        chk({tag, "_drop"}, start, 0);
        tick(dd - 1);
        chk({tag, "_noack"}, ack, 0);
        done = 1'b1;
        tick(1);
        chk({tag, "_ack"}, ack, exp_ack);
        chk({tag, "_err"}, err, 0);
        req = req & ~clr;
        for (int i = 1; i < dl; i++) begin
            tick(1);
            if (ack != 0 || start) extra++;
        end
        chk({tag, "_once"}, extra, 0);
        done = 1'b0;
        cs = 1'b1;
    endtask

    initial begin
        int extra;
        do_reset();
        chk("rst_start", start, 0);
        chk("rst_din", din, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);

        // single frame, latency and long done wait
        req = 4'b0001;
        tick(1);
        chk("t1_lat", start, 1);
        chk("t1_busy", busy, 1);
        serve("t1", 4'b0001, 12'hA5C, 29, 300, 2, 4'b0001);
        tick(2);
        chk("t1_idle", busy, 0);

        // reset in WAIT_DONE with the master still busy
        req = 4'b0010;
        tick(1);
        chk("t5_grant", start, 1);
        chk("t5_din", din, 12'h1B9);
        cs = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t5_rst_start", start, 0);
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_busy", busy, 0);
        req = 4'b0011;
        extra = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (start || ack != 0) extra++;
        end
        chk("t5_wait", extra, 0);
        cs = 1'b1;
        serve("t5", 4'b0001, 12'hA5C, 2, 5, 1, 4'b0011);
        tick(2);

        // all requesters held high
        do_reset();
        req = 4'b1111;
        serve("t2a", 4'b0001, 12'hA5C, 3, 10, 2, 4'b0000);
        serve("t2b", 4'b0010, 12'h1B9, 3, 10, 2, 4'b0000);
        serve("t2c", 4'b0100, 12'h47E, 3, 10, 2, 4'b0000);
        serve("t2d", 4'b1000, 12'h8D3, 3, 10, 2, 4'b0000);
        serve("t2e", 4'b0001, 12'hA5C, 3, 10, 2, 4'b1111);
        tick(2);

        // long done level gives one ack
        req = 4'b0001;
        serve("t4", 4'b0001, 12'hA5C, 2, 4, 11, 4'b0001);
        tick(2);

        // rotation from ptr=3, then withdrawal before grant
        req = 4'b0100;
        serve("t6a", 4'b0100, 12'h47E, 2, 4, 1, 4'b0100);
        tick(1);
        req = 4'b0110;
        serve("t6b", 4'b0010, 12'h1B9, 2, 4, 1, 4'b0010);
        serve("t6c", 4'b0100, 12'h47E, 2, 4, 1, 4'b0100);
        tick(1);
        req = 4'b0110;
        serve("t6d", 4'b0010, 12'h1B9, 2, 4, 1, 4'b0110);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (start || ack != 0) extra++;
        end
        chk("t6_nogrant", extra, 0);
        chk("t6_idle", busy, 0);

        // watchdog on the short-timeout instance
        do_reset();
        req = 4'b0001;
        tick(1);
        chk("t3_start", t_start, 1);
        tick(63);
        chk("t3_pre_ack", t_ack, 0);
        chk("t3_pre_start", t_start, 1);
        tick(1);
        chk("t3_ack", t_ack, 4'b0001);
        chk("t3_err", t_err, 1);
        chk("t3_drop", t_start, 0);
        req = 4'b0000;
        tick(1);
        chk("t3_ack_pulse", t_ack, 0);
        chk("t3_err_pulse", t_err, 0);
        req = 4'b0010;
        tick(1);
        chk("t3_next_start", t_start, 1);
        chk("t3_next_din", t_din, 12'h1B9);
        t_cs = 1'b0;
        tick(1);
        chk("t3_next_drop", t_start, 0);
        tick(3);
        t_done = 1'b1;
        tick(1);
        chk("t3_next_ack", t_ack, 4'b0010);
        chk("t3_next_err", t_err, 0);
        req = 4'b0000;
        t_done = 1'b0;
        t_cs = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
